// File: rtl/mem_write_ctrl_if.sv
// FIFO read-side and RAM read-port bundle for the memory-domain write controller.
// The controller is the master: it issues pops and answers random-access reads.
interface mem_write_ctrl_if #(
   parameter int AW = 4
);

   logic          fifo_empty;
   logic [7:0]    fifo_data;
   logic          rd_en_mem;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          rd_valid;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      input  rd_req,
      input  rd_addr,
      output rd_en_mem,
      output rd_data,
      output rd_valid
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      output rd_req,
      output rd_addr,
      input  rd_en_mem,
      input  rd_data,
      input  rd_valid
   );

endinterface

// File: rtl/mem_write_ctrl.sv
// Drains bytes from the clock-crossing FIFO into a local byte RAM, either as a
// circular log (WRAP=1) or a one-shot buffer (WRAP=0), with a 1-cycle read port.
module mem_write_ctrl #(
   parameter int AW   = 4,
   parameter bit WRAP = 1'b1
) (
   input  logic            clk_mem,
   input  logic            reset,
   input  logic            clear,
   mem_write_ctrl_if.master bus,
   output logic [AW-1:0]   wr_ptr,
   output logic [AW:0]     byte_count,
   output logic            mem_full,
   output logic            busy
);

   localparam int          DEPTH     = 2**AW;
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);
   localparam logic [AW-1:0] ONE_PTR = AW'(1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WRITE
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        write_en;
   logic [AW:0] count_inc;
   logic [7:0]  mem [DEPTH];

   // A one-shot buffer refuses to pop once it holds DEPTH bytes.
   function automatic logic can_pop(input logic empty, input logic [AW:0] cnt);
      return !empty && !(!WRAP && (cnt == DEPTH_CNT));
   endfunction

   assign count_inc = (byte_count == DEPTH_CNT) ? byte_count : byte_count + ONE_CNT;
   assign mem_full  = (byte_count == DEPTH_CNT);
   assign busy      = (state != IDLE);

   always_comb begin
      state_next = state;
      write_en   = 1'b0;
      case (state)
         IDLE: begin
            if (can_pop(bus.fifo_empty, byte_count)) begin
               state_next = REQ;
            end
         end
         REQ: begin
            state_next = WRITE;
         end
         WRITE: begin
            write_en   = 1'b1;
            state_next = can_pop(bus.fifo_empty, count_inc) ? REQ : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // A flush abandons whatever byte is in flight, including the one popped in REQ.
      if (clear) begin
         state_next = IDLE;
         write_en   = 1'b0;
      end
   end

   always_ff @(posedge clk_mem) begin
      if (reset) begin
         state         <= IDLE;
         bus.rd_en_mem <= 1'b0;
      end else begin
         state         <= state_next;
         bus.rd_en_mem <= (state_next == REQ);
      end
   end

   always_ff @(posedge clk_mem) begin
      if (reset || clear) begin
         wr_ptr     <= '0;
         byte_count <= '0;
      end else if (write_en) begin
         wr_ptr     <= wr_ptr + ONE_PTR;
         byte_count <= count_inc;
      end
   end

   // RAM storage has no reset; a reset during WRITE still blocks the write.
   always_ff @(posedge clk_mem) begin
      if (write_en && !reset) begin
         mem[wr_ptr] <= bus.fifo_data;
      end
   end

   always_ff @(posedge clk_mem) begin
      if (reset) begin
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= 8'h00;
      end else begin
         bus.rd_valid <= bus.rd_req;
         if (bus.rd_req) begin
            bus.rd_data <= mem[bus.rd_addr];
         end
      end
   end

endmodule

// File: tb/tb_mem_write_ctrl.sv
// Scoreboard bench for mem_write_ctrl: one circular-log and one one-shot instance,
// each fed by a queue-modelled FIFO; read results are checked against queued expectations.
module tb_mem_write_ctrl;

   localparam int AW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic clearA;

   mem_write_ctrl_if #(.AW(AW)) busA ();
   mem_write_ctrl_if #(.AW(AW)) busB ();

   logic [AW-1:0] wrPtrA, wrPtrB;
   logic [AW:0]   countA, countB;
   logic          fullA, fullB, busyA, busyB;

   int total = 0;
   int bad   = 0;
   int popsA = 0;
   int popsB = 0;
   int waited;
   logic prevEnA = 1'b0;
   logic prevEnB = 1'b0;

   logic [7:0] fifoA [$];
   logic [7:0] fifoB [$];
   logic [7:0] expA  [$];
   logic [7:0] expB  [$];

   mem_write_ctrl #(.AW(AW), .WRAP(1'b1)) dutA (
      .clk_mem    (clk),
      .reset      (reset),
      .clear      (clearA),
      .bus        (busA),
      .wr_ptr     (wrPtrA),
      .byte_count (countA),
      .mem_full   (fullA),
      .busy       (busyA)
   );

   mem_write_ctrl #(.AW(AW), .WRAP(1'b0)) dutB (
      .clk_mem    (clk),
      .reset      (reset),
      .clear      (1'b0),
      .bus        (busB),
      .wr_ptr     (wrPtrB),
      .byte_count (countB),
      .mem_full   (fullB),
      .busy       (busyB)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input bit which, input logic [7:0] b);
      if (!which) fifoA.push_back(b);
      else        fifoB.push_back(b);
   endtask

   task automatic readMem(input bit which, input logic [AW-1:0] addr, input logic [7:0] exp);
      if (!which) begin
         busA.rd_req  = 1'b1;
         busA.rd_addr = addr;
         expA.push_back(exp);
      end else begin
         busB.rd_req  = 1'b1;
         busB.rd_addr = addr;
         expB.push_back(exp);
      end
      @(negedge clk);
      busA.rd_req = 1'b0;
      busB.rd_req = 1'b0;
   endtask

   task automatic waitPop(input bit which, input int budget, output int n);
      bit found = 1'b0;
      n = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         n++;
         if ((!which && busA.rd_en_mem) || (which && busB.rd_en_mem)) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput(which ? "popTimeoutB" : "popTimeoutA", 32'(found), 32'd1);
   endtask

   task automatic pulseClearA();
      clearA = 1'b1;
      @(negedge clk);
      clearA = 1'b0;
   endtask

   // FIFO model pops on the strobe; the empty flag settles just after the edge
   // so pushes made at the same negedge are seen by the next rising edge.
   always begin
      @(negedge clk);
      if (busA.rd_en_mem) begin
         popsA++;
         checkOutput("popGapA", 32'(prevEnA), 32'd0);
         checkOutput("underflowA", 32'(fifoA.size() > 0), 32'd1);
         if (fifoA.size() > 0) busA.fifo_data = fifoA.pop_front();
      end
      if (busB.rd_en_mem) begin
         popsB++;
         checkOutput("popGapB", 32'(prevEnB), 32'd0);
         checkOutput("underflowB", 32'(fifoB.size() > 0), 32'd1);
         if (fifoB.size() > 0) busB.fifo_data = fifoB.pop_front();
      end
      prevEnA = busA.rd_en_mem;
      prevEnB = busB.rd_en_mem;
      if (busA.rd_valid === 1'b1) begin
         if (expA.size() == 0) checkOutput("rdSpuriousA", 32'd1, 32'd0);
         else checkOutput("rdDataA", 32'(busA.rd_data), 32'(expA.pop_front()));
      end
      if (busB.rd_valid === 1'b1) begin
         if (expB.size() == 0) checkOutput("rdSpuriousB", 32'd1, 32'd0);
         else checkOutput("rdDataB", 32'(busB.rd_data), 32'(expB.pop_front()));
      end
      #1;
      busA.fifo_empty = (fifoA.size() == 0);
      busB.fifo_empty = (fifoB.size() == 0);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset        = 1'b1;
      clearA       = 1'b0;
      busA.rd_req  = 1'b0;
      busA.rd_addr = '0;
      busB.rd_req  = 1'b0;
      busB.rd_addr = '0;
      repeat (3) @(negedge clk);

      checkOutput("rstRdEnA", 32'(busA.rd_en_mem), 32'd0);
      checkOutput("rstPtrA", 32'(wrPtrA), 32'd0);
      checkOutput("rstCountA", 32'(countA), 32'd0);
      checkOutput("rstFullA", 32'(fullA), 32'd0);
      checkOutput("rstBusyA", 32'(busyA), 32'd0);
      checkOutput("rstValidA", 32'(busA.rd_valid), 32'd0);
      checkOutput("rstDataA", 32'(busA.rd_data), 32'd0);
      checkOutput("rstBusyB", 32'(busyB), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Three bytes: pops two cycles apart, busy drops after the last write.
      applyStimulus(0, 8'hA5);
      applyStimulus(0, 8'h3C);
      applyStimulus(0, 8'h7E);
      waitPop(0, 10, waited);
      checkOutput("pop1Latency", 32'(waited), 32'd1);
      waitPop(0, 10, waited);
      checkOutput("pop2Spacing", 32'(waited), 32'd2);
      waitPop(0, 10, waited);
      checkOutput("pop3Spacing", 32'(waited), 32'd2);
      @(negedge clk);
      checkOutput("busyInWrite", 32'(busyA), 32'd1);
      @(negedge clk);
      checkOutput("busyDone", 32'(busyA), 32'd0);
      checkOutput("ptrAfter3", 32'(wrPtrA), 32'd3);
      checkOutput("countAfter3", 32'(countA), 32'd3);
      readMem(0, 4'd0, 8'hA5);
      readMem(0, 4'd1, 8'h3C);
      readMem(0, 4'd2, 8'h7E);
      @(negedge clk);

      // One-shot fill: 20 bytes offered, only 16 accepted.
      for (int i = 0; i < 20; i++) applyStimulus(1, 8'(i));
      repeat (50) @(negedge clk);
      checkOutput("fillPops", 32'(popsB), 32'd16);
      checkOutput("fillFull", 32'(fullB), 32'd1);
      checkOutput("fillCount", 32'(countB), 32'd16);
      checkOutput("fillPtr", 32'(wrPtrB), 32'd0);
      checkOutput("fillRdEn", 32'(busB.rd_en_mem), 32'd0);
      checkOutput("fillFifoLeft", 32'(fifoB.size()), 32'd4);
      if (fifoB.size() > 0) checkOutput("fillFifoHead", 32'(fifoB[0]), 32'h10);
      repeat (5) @(negedge clk);
      checkOutput("fillStillHalted", 32'(popsB), 32'd16);
      checkOutput("fillIdle", 32'(busyB), 32'd0);
      readMem(1, 4'd0, 8'h00);
      readMem(1, 4'd7, 8'h07);
      readMem(1, 4'd15, 8'h0F);
      @(negedge clk);

      // Circular log: 18 bytes overwrite the two oldest entries.
      pulseClearA();
      checkOutput("clearPtr", 32'(wrPtrA), 32'd0);
      checkOutput("clearCount", 32'(countA), 32'd0);
      for (int i = 0; i < 18; i++) applyStimulus(0, 8'(i));
      repeat (45) @(negedge clk);
      checkOutput("wrapCount", 32'(countA), 32'd16);
      checkOutput("wrapFull", 32'(fullA), 32'd1);
      checkOutput("wrapPtr", 32'(wrPtrA), 32'd2);
      readMem(0, 4'd0, 8'h10);
      readMem(0, 4'd1, 8'h11);
      readMem(0, 4'd2, 8'h02);
      readMem(0, 4'd15, 8'h0F);
      @(negedge clk);

      // Clear during REQ discards the popped byte.
      pulseClearA();
      applyStimulus(0, 8'h55);
      waitPop(0, 10, waited);
      pulseClearA();
      checkOutput("clrReqRdEn", 32'(busA.rd_en_mem), 32'd0);
      checkOutput("clrReqBusy", 32'(busyA), 32'd0);
      checkOutput("clrReqPtr", 32'(wrPtrA), 32'd0);
      checkOutput("clrReqCount", 32'(countA), 32'd0);
      repeat (4) @(negedge clk);
      checkOutput("clrReqStillZero", 32'(countA), 32'd0);
      readMem(0, 4'd0, 8'h10);
      applyStimulus(0, 8'h66);
      repeat (6) @(negedge clk);
      readMem(0, 4'd0, 8'h66);
      checkOutput("after66Ptr", 32'(wrPtrA), 32'd1);
      checkOutput("after66Count", 32'(countA), 32'd1);

      // Read colliding with a write to the same address returns the old byte.
      applyStimulus(0, 8'h21);
      applyStimulus(0, 8'h22);
      applyStimulus(0, 8'h23);
      applyStimulus(0, 8'h11);
      repeat (12) @(negedge clk);
      readMem(0, 4'd4, 8'h11);
      pulseClearA();
      applyStimulus(0, 8'h31);
      applyStimulus(0, 8'h32);
      applyStimulus(0, 8'h33);
      applyStimulus(0, 8'h34);
      applyStimulus(0, 8'h9A);
      for (int i = 0; i < 5; i++) waitPop(0, 10, waited);
      @(negedge clk);
      readMem(0, 4'd4, 8'h11);
      readMem(0, 4'd4, 8'h9A);
      @(negedge clk);
      checkOutput("validStrobe", 32'(busA.rd_valid), 32'd0);
      checkOutput("dataHold", 32'(busA.rd_data), 32'h9A);
      checkOutput("collPtr", 32'(wrPtrA), 32'd5);

      // Reset in WRITE drops the in-flight byte; operation resumes afterwards.
      applyStimulus(0, 8'hEE);
      waitPop(0, 10, waited);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rstWrRdEn", 32'(busA.rd_en_mem), 32'd0);
      checkOutput("rstWrPtr", 32'(wrPtrA), 32'd0);
      checkOutput("rstWrCount", 32'(countA), 32'd0);
      checkOutput("rstWrFull", 32'(fullA), 32'd0);
      checkOutput("rstWrBusy", 32'(busyA), 32'd0);
      checkOutput("rstWrValid", 32'(busA.rd_valid), 32'd0);
      checkOutput("rstWrData", 32'(busA.rd_data), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      readMem(0, 4'd5, 8'h05);
      applyStimulus(0, 8'h77);
      repeat (6) @(negedge clk);
      readMem(0, 4'd0, 8'h77);
      checkOutput("resumePtr", 32'(wrPtrA), 32'd1);
      checkOutput("resumeCount", 32'(countA), 32'd1);
      repeat (3) @(negedge clk);

      checkOutput("expADrained", 32'(expA.size()), 32'd0);
      checkOutput("expBDrained", 32'(expB.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
